// File: rtl/mux_arbiter.sv
// mux_arbiter: round-robin arbiter that shares one registered valid/ready output stage
// between two requesters, drives the 2:1 mux selector and caps each grant at MAX_BURST beats.
module mux_arbiter #(
    parameter int DATA_WIDTH = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_0,
    input  logic [DATA_WIDTH-1:0] in_0,
    output logic                  gnt_0,
    input  logic                  req_1,
    input  logic [DATA_WIDTH-1:0] in_1,
    output logic                  gnt_1,
    output logic                  selector,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  out_valid,
    input  logic                  out_ready
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] GRANT0 = 2'd1;
    localparam logic [1:0] GRANT1 = 2'd2;

    logic [1:0] state, state_nx, other;
    logic [7:0] count, count_inc, count_nx;
    logic       ptr, stage_free, xfer, req_cur, req_oth, burst_done, enter;

    assign stage_free = !out_valid | out_ready;
    assign gnt_0      = (state == GRANT0) & stage_free;
    assign gnt_1      = (state == GRANT1) & stage_free;
    assign xfer       = (gnt_0 & req_0) | (gnt_1 & req_1);
    assign req_cur    = (state == GRANT1) ? req_1 : req_0;
    assign req_oth    = (state == GRANT1) ? req_0 : req_1;
    assign other      = (state == GRANT0) ? GRANT1 : GRANT0;
    assign count_inc  = count + 8'(xfer);
    assign burst_done = count_inc == 8'(MAX_BURST);
    assign enter      = (state_nx != state) & (state_nx != IDLE);

    // Transitions see the post-transfer beat count so a full burst hands over without a bubble.
    always_comb begin
        state_nx = state;
        count_nx = count_inc;
        if (state == IDLE)
            state_nx = (req_0 & req_1) ? (ptr ? GRANT1 : GRANT0) : req_0 ? GRANT0 : req_1 ? GRANT1 : IDLE;
        else if (!req_cur)
            state_nx = req_oth ? other : IDLE;
        else if (burst_done) begin
            if (req_oth)
                state_nx = other;
            else
                count_nx = '0;
        end
        if (enter)
            count_nx = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            ptr       <= 1'b0;
            selector  <= 1'b0;
            data_out  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (xfer) begin
                data_out  <= selector ? in_1 : in_0;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            // A stalled output stage freezes arbitration entirely.
            if (stage_free) begin
                state <= state_nx;
                count <= count_nx;
                if (enter) begin
                    ptr      <= (state_nx == GRANT0);
                    selector <= (state_nx == GRANT1);
                end
            end
        end
    end
endmodule

// File: doc/mux_arbiter.md
Name: mux_arbiter

Overview:
- Round-robin arbiter and sequencer for the 2:1, 4-bit multiplexer datapath.
- Shares one output channel between two requesters and drives the mux selector.
- Registers the selected word into a valid/ready output stage.
- Enforces a maximum burst length per grant so neither requester starves the other.

Parameters:
- DATA_WIDTH, 4: width of each input word and of data_out.
- MAX_BURST, 4: maximum beats accepted from one requester before a forced handover, if the other requester is waiting. Legal range 1..255.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_0  input  1  requester 0 has a word on in_0.
- in_0  input  DATA_WIDTH  requester 0 data.
- gnt_0  output  1  requester 0 word accepted this cycle when req_0 & gnt_0.
- req_1  input  1  requester 1 has a word on in_1.
- in_1  input  DATA_WIDTH  requester 1 data.
- gnt_1  output  1  requester 1 word accepted this cycle when req_1 & gnt_1.
- selector  output  1  mux select: 0 = in_0, 1 = in_1.
- data_out  output  DATA_WIDTH  registered output word.
- out_valid  output  1  data_out holds an unconsumed word.
- out_ready  input  1  downstream accepts data_out this cycle when out_valid & out_ready.

Behaviour:
- Reset (async assert, released synchronously to clk):
  - state = IDLE, selector = 0, data_out = 0, out_valid = 0, beat count = 0.
  - Priority pointer set to prefer requester 0.
  - gnt_0 = gnt_1 = 0.
- States: IDLE, GRANT0, GRANT1.
- stage_free = !out_valid | out_ready (combinational).
- gnt_0 = (state==GRANT0) & stage_free; gnt_1 = (state==GRANT1) & stage_free. Both are combinational and never high together.
- Transfer on req_x & gnt_x:
  - data_out <= in_x, out_valid <= 1, beat count += 1.
  - Otherwise, if out_ready, out_valid <= 0; data_out holds its value.
- Latency:
  - One cycle IDLE→GRANT arbitration; no grant in IDLE.
  - Accepted word appears on data_out the cycle after the transfer.
  - Steady throughput of 1 word/cycle when out_ready is held high.
- selector:
  - Registered; equals 1 in GRANT1 and 0 in GRANT0.
  - Holds its last value in IDLE.
- IDLE transitions:
  - Only req_k set → GRANTk.
  - Both set → requester indicated by the priority pointer.
  - Neither set → stay in IDLE.
- GRANTx transitions (evaluated each edge, after any transfer that edge):
  - req_x low and req_other high → GRANTother.
  - req_x low and req_other low → IDLE.
  - Count reaches MAX_BURST and req_other high → GRANTother (forced handover).
  - Count reaches MAX_BURST and req_other low → stay in GRANTx, count reset to 0.
  - Otherwise stay in GRANTx.
- Every entry into GRANTx sets count = 0 and pointer = the other requester.
- Backpressure:
  - While out_valid & !out_ready, no grants are issued, count is frozen and state holds.
  - A req_x drop during backpressure is handled by the normal transitions on the next edge.
- Requester rules:
  - A requester must hold req_x and in_x stable until granted.
  - The arbiter never drops a granted word.
- Reset mid-burst: all state returns to the reset values immediately; any pending data_out word is discarded (out_valid = 0).
- Count width is 8 bits and never exceeds MAX_BURST.

Test Plan:
- Reset: rst_n low mid-run with out_valid=1 → out_valid, data_out, selector, gnt_0, gnt_1 are all 0 immediately; first grant after release goes to requester 0 when both request.
- Single requester: req_1=1, in_1=4'hA, out_ready=1 → gnt_1 high from cycle 2 (after IDLE), selector=1, data_out=4'hA with out_valid=1 on the following cycle; gnt_0 stays 0.
- Fairness: req_0 and req_1 both held high, in_0=4'h3, in_1=4'hC, MAX_BURST=4, out_ready=1 → data_out sequence 3,3,3,3,C,C,C,C,3,…; selector toggles every 4 beats; no idle cycle at handover.
- Backpressure: GRANT0 streaming, out_ready=0 for 3 cycles → gnt_0=0 and data_out/out_valid frozen during stall; beat count unchanged; streaming resumes on the cycle out_ready returns to 1.
- Early release: GRANT0 after 2 beats, req_0 drops and req_1 is high → next edge in GRANT1, count restarts at 0, and requester 1 gets a full 4-beat burst.
- Exhaustive mux check: sweep in_0 and in_1 over all 16×16 values, alternating single requests → every output word equals the granted input and selector matches its source; the bench flags any mismatch and reports pass/fail at end.
